wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, legal range 1..15: consecutive blocked cycles allowed before a forced buffer drain.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports pipe_we_i / pipe_waddr_i / pipe_wdata_i  input  1/5/32  writeback request from the ex_wb pipeline register.
REQ-005 SHALL have ports mc_req_i / mc_waddr_i / mc_wdata_i  input  1/5/32  result request from the multi-cycle unit (divider).
REQ-006 SHALL have port mc_ack_o  output  1  result accepted; transfer occurs when mc_req_i and mc_ack_o are both high in the same cycle.
REQ-007 SHALL have ports reg_we_o / reg_waddr_o / reg_wdata_o  output  1/5/32  register-file write port.
REQ-008 SHALL have port stall_flag_o  output  1  pipeline hold request, wired to the ex_wb stall input.

Function
REQ-009 SHALL treat a request with waddr = 0 as no write; it never occupies the write port or the buffer.
REQ-010 SHALL keep a one-entry buffer (addr 5b, data 32b), a state register {IDLE, HELD, FORCE} and a 4-bit wait counter.
REQ-011 SHALL drive reg_* combinationally from the current state and inputs; write latency is zero from the selected source.
REQ-012 SHALL give the pipeline write priority: pipe_we_i=1 with nonzero address -> reg_we_o=1, reg_waddr_o/reg_wdata_o = pipe inputs (except in FORCE).
REQ-013 SHALL assert mc_ack_o only in IDLE; an accepted nonzero-address result is captured into the buffer, and next state is HELD.
REQ-014 SHALL, in HELD with the pipeline port free, write the buffer (reg_we_o=1), clear the counter, and return to IDLE.
REQ-015 SHALL, in HELD with the pipeline port busy and pipe_waddr_i equal to the buffered address, discard the buffer (superseded by the younger write), clear the counter, and go to IDLE.
REQ-016 SHALL, in HELD with the pipeline port busy and a different address, increment the counter; on the cycle the counter reaches STARVE_LIMIT the next state is FORCE.
REQ-017 SHALL, in FORCE, assert stall_flag_o for exactly that one cycle, write the buffer regardless of the pipe inputs, clear the counter, and go to IDLE.
REQ-018 SHALL rely on ex_wb holding its outputs during the stall, so the held pipeline write is performed in the cycle after FORCE.
REQ-019 SHALL hold stall_flag_o low in IDLE and HELD.

Reset
REQ-020 SHALL, while rst=0, force state=IDLE, buffer=0, counter=0, and outputs reg_we_o=0, mc_ack_o=0, stall_flag_o=0, reg_waddr_o=0, reg_wdata_o=0.
REQ-021 SHALL discard a buffered result lost to reset mid-operation, with no write after reset release.
REQ-022 SHALL accept requests on the first rising edge after rst deasserts.

Configuration
REQ-023 SHALL, with WB_ARB_BYPASS_EN defined, in IDLE with the pipeline port free and mc_req_i=1 (nonzero address), write mc_waddr_i/mc_wdata_i directly in the same cycle, ack it, and stay IDLE.
REQ-024 SHALL, without WB_ARB_BYPASS_EN, always capture accepted results into the buffer, giving an earliest register-file write one cycle after acceptance.

Verification
REQ-025 SHALL cover: idle pipe, mc_req x5=0x1234 at cycle 0 -> ack cycle 0, reg write x5=0x1234 at cycle 1 (cycle 0 with BYPASS).
REQ-026 SHALL cover: mc x7 accepted, pipe writes x3 for 4 cycles, STARVE_LIMIT=4 -> stall_flag_o=1 on the 5th HELD-following cycle, x7 written that cycle, x3 written the next cycle.
REQ-027 SHALL cover: buffer holds x9=0xAAAA, pipe writes x9=0x5555 -> only 0x5555 written, state IDLE, no later x9 write.
REQ-028 SHALL cover: mc_req to x0 and pipe write to x0 -> reg_we_o stays 0, mc_ack_o=1, no HELD entry.
REQ-029 SHALL cover: rst pulled low while HELD with counter=2 -> all outputs 0 immediately; after release, no buffered write and mc_ack_o=1.
REQ-030 SHALL cover: mc_req held high continuously while HELD -> mc_ack_o=0 until drain, next result accepted the cycle after drain.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ex_wb pipeline writebacks and multi-cycle unit results onto one
// register-file write port. The pipeline has priority; a multi-cycle result waits in a
// one-entry buffer and is force-drained with a one-cycle pipeline stall once it has
// been blocked for STARVE_LIMIT consecutive cycles.
// Optional feature: define WB_ARB_BYPASS_EN to write an accepted result straight
// through when the pipeline port is free, instead of always buffering it first.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we_i,
  input  logic [4:0]  pipe_waddr_i,
  input  logic [31:0] pipe_wdata_i,
  input  logic        mc_req_i,
  input  logic [4:0]  mc_waddr_i,
  input  logic [31:0] mc_wdata_i,
  output logic        mc_ack_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        stall_flag_o
);
  typedef enum logic [1:0] {IDLE, HELD, FORCE} state_e;
  state_e      state_q, state_d;
  logic [4:0]  baddr_q, baddr_d;
  logic [31:0] bdata_q, bdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        pipe_v, mc_v, mc_acc;
  // writes to x0 are not writes at all
  assign pipe_v       = pipe_we_i && (pipe_waddr_i != 5'd0);
  assign mc_v         = mc_req_i && (mc_waddr_i != 5'd0);
  assign mc_ack_o     = rst && (state_q == IDLE);
  assign mc_acc       = mc_ack_o && mc_v;
  assign stall_flag_o = rst && (state_q == FORCE);
  // outputs are held at zero for the whole time reset is asserted
  assign reg_we_o     = rst && we;
  assign reg_waddr_o  = rst ? waddr : 5'd0;
  assign reg_wdata_o  = rst ? wdata : 32'd0;
  // write-port selection and next-state logic
  always_comb begin
    state_d = state_q;
    baddr_d = baddr_q;
    bdata_d = bdata_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    waddr   = 5'd0;
    wdata   = 32'd0;
    case (state_q)
      IDLE: begin
        if (pipe_v) begin
          we    = 1'b1;
          waddr = pipe_waddr_i;
          wdata = pipe_wdata_i;
        end
`ifdef WB_ARB_BYPASS_EN
        else if (mc_acc) begin
          we    = 1'b1;
          waddr = mc_waddr_i;
          wdata = mc_wdata_i;
        end
        if (mc_acc && pipe_v) begin
          baddr_d = mc_waddr_i;
          bdata_d = mc_wdata_i;
          state_d = HELD;
        end
`else
        if (mc_acc) begin
          baddr_d = mc_waddr_i;
          bdata_d = mc_wdata_i;
          state_d = HELD;
        end
`endif
      end
      HELD: begin
        if (!pipe_v) begin
          we      = 1'b1;
          waddr   = baddr_q;
          wdata   = bdata_q;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          we    = 1'b1;
          waddr = pipe_waddr_i;
          wdata = pipe_wdata_i;
          if (pipe_waddr_i == baddr_q) begin
            cnt_d   = 4'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == 4'(STARVE_LIMIT)) state_d = FORCE;
          end
        end
      end
      FORCE: begin
        we      = 1'b1;
        waddr   = baddr_q;
        wdata   = bdata_q;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, buffer and starvation counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baddr_q <= 5'd0;
      bdata_q <= 32'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      baddr_q <= baddr_d;
      bdata_q <= bdata_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
